spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI slave endpoint for the 12-bit SPI master link: one frame = one 12-bit word each way, MSB first.
//  Inputs sclk/cs/mosi are oversampled on clk. mosi is sampled on sclk falling edges.
//  miso is driven on sclk rising edges, matching the master (mosi out on rise, miso in on fall).
//  Sits on the peripheral side; the local user loads tx words and receives rx words with a valid pulse.
// PARAMETERS
//  DATA_WIDTH   12  bits per frame (master fixes 12)
//  SYNC_STAGES  2   synchronizer flops on sclk, cs, mosi (>=2)
// PORTS
//  clk         in   1   system clock; requirement f_clk >= 8*f_sclk
//  rst         in   1   reset, synchronous, active-high
//  sclk        in   1   SPI clock from master (async to clk)
//  cs          in   1   chip select from master, active low
//  mosi        in   1   serial data master->slave
//  miso        out  1   serial data slave->master
//  tx_data     in   12  word to return in a subsequent frame
//  tx_load     in   1   write tx_data into holding reg (accepted only when tx_ready=1)
//  tx_ready    out  1   holding reg empty
//  rx_data     out  12  last complete received word
//  rx_valid    out  1   1-cycle pulse: rx_data updated
//  busy        out  1   1 while state != IDLE
//  tx_underrun out  1   1-cycle pulse: frame started with empty holding reg
//  frame_err   out  1   1-cycle pulse: cs deasserted before 12 bits received
// BEHAVIOUR
//  Reset: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, tx_underrun=0, frame_err=0.
//   Synchronizers reset to sclk=0, cs=1, mosi=0; edge history reg = 0; state=IDLE; bit_cnt=0.
//   Reset mid-frame aborts the frame with no pulses; holding reg is emptied.
//  Sync/edges: sclk_s, cs_s, mosi_s = SYNC_STAGES-flop copies. rise = ~sclk_d & sclk_s; fall = sclk_d & ~sclk_s.
//   Pin edge to miso update = SYNC_STAGES+1 clk cycles.
//  States: IDLE, ACTIVE, DONE.
//   IDLE: miso=0, bit_cnt=0. When cs_s=0 -> ACTIVE.
//    Same cycle: shift_tx <= holding reg if full (then tx_ready<=1).
//    Otherwise shift_tx <= 0 and tx_underrun pulses.
//   ACTIVE: on rise -> miso <= shift_tx[11], shift_tx <<= 1.
//    On fall -> shift_rx <= {shift_rx[10:0], mosi_s}, bit_cnt++.
//    When the 12th fall is sampled: rx_data <= completed word, rx_valid=1 next cycle, -> DONE.
//    cs_s=1 while ACTIVE -> frame_err pulse, rx_data unchanged, -> IDLE.
//   DONE: miso=0. Further sclk edges are ignored. cs_s=1 -> IDLE (no pulse).
//  tx_load with tx_ready=1: holding reg <= tx_data, tx_ready=0 next cycle. With tx_ready=0: ignored (no overwrite).
//  tx_load in the frame-start cycle with holding reg empty: this frame still underruns (sends zeros).
//   The loaded word is kept for the next frame.
//  Frame start consumes the holding reg as it was at the start of that cycle.
//  rise and fall never coincide (single sclk); cs_s=1 takes priority over any edge in the same cycle.
//  cs low again immediately after high (back-to-back): IDLE->ACTIVE on the next cycle; no gap cycles required.
//  Bits beyond 12 in one frame: not shifted, no second rx_valid, miso held 0.
// TESTING
//  1 Load tx 0x3F1; master sends 0xA5C (full duplex)
//    -> rx_data=0xA5C with one rx_valid pulse; master dout=0x3F1; busy falls after cs high.
//  2 No tx_load before frame; master sends 0x001
//    -> tx_underrun pulse at cs fall; miso all 0; rx_data=0x001.
//  3 cs rises after 5 falls
//    -> frame_err pulse; rx_valid stays 0; rx_data keeps its prior value; next frame 0x7E7 received correctly.
//  4 Two back-to-back frames, tx 0x123 then 0x456 (reloaded when tx_ready=1)
//    -> master receives 0x123, 0x456; two rx_valid pulses.
//  5 tx_load 0xAAA then tx_load 0x555 while tx_ready=0
//    -> master receives 0xAAA; 0x555 is dropped.
//  6 rst asserted after 6 bits
//    -> all outputs at reset values next cycle; no rx_valid/frame_err pulse; next frame normal.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI slave pins plus local tx/rx user handshake, bundled for the slave endpoint.
// No logic here; the slave modport is the endpoint side, master is the driver/bench side.
interface spi_slave_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  tx_underrun;
  logic                  frame_err;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_err
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_err
  );
endinterface

// File: rtl/spi_slave.sv
// Oversampled 12-bit SPI slave; pin edge to miso = SYNC_STAGES+1 clks, rx_valid 1 clk after last fall.
// One-deep tx holding reg: tx_load is ignored while tx_ready=0; an empty reg at frame start sends zeros.
module spi_slave #(
  parameter int DATA_WIDTH  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  spi_slave_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   rise, fall, last_fall;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_tx, shift_rx, hold, rx_data;
  logic                   tx_ready, miso, rx_valid, tx_underrun, frame_err;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign rise      = ~sclk_d & sclk_s;
  assign fall      = sclk_d & ~sclk_s;
  assign last_fall = fall && (bit_cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // cs_s high outranks any sclk edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_s) state_d = ACTIVE;
      ACTIVE: begin
        if (cs_s)           state_d = IDLE;
        else if (last_fall) state_d = DONE;
      end
      DONE:    if (cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      tx_ready    <= 1'b1;
      shift_tx    <= '0;
      shift_rx    <= '0;
      rx_data     <= '0;
      bit_cnt     <= '0;
      miso        <= 1'b0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      if (bus.tx_load && tx_ready) begin
        hold     <= bus.tx_data;
        tx_ready <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          miso    <= 1'b0;
          bit_cnt <= '0;
          // Frame start uses the holding reg as it stood before this cycle's load.
          if (!cs_s) begin
            if (!tx_ready) begin
              shift_tx <= hold;
              tx_ready <= 1'b1;
            end else begin
              shift_tx    <= '0;
              tx_underrun <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            frame_err <= 1'b1;
          end else if (rise) begin
            miso     <= shift_tx[DATA_WIDTH-1];
            shift_tx <= shift_tx << 1;
          end else if (fall) begin
            shift_rx <= {shift_rx[DATA_WIDTH-2:0], mosi_s};
            bit_cnt  <= bit_cnt + 1'b1;
            if (last_fall) begin
              rx_data  <= {shift_rx[DATA_WIDTH-2:0], mosi_s};
              rx_valid <= 1'b1;
            end
          end
        end
        DONE:    miso <= 1'b0;
        default: miso <= 1'b0;
      endcase
    end
  end

  assign bus.miso        = miso;
  assign bus.tx_ready    = tx_ready;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.busy        = (state_q != IDLE);
  assign bus.tx_underrun = tx_underrun;
  assign bus.frame_err   = frame_err;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: table of frames, hand-written corner sequences, then random frames vs a word-level model.
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(12)) bus();
  spi_slave #(.DATA_WIDTH(12), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int n_valid = 0, n_under = 0, n_err = 0;

  always @(negedge clk) begin
    if (bus.rx_valid)    n_valid++;
    if (bus.tx_underrun) n_under++;
    if (bus.frame_err)   n_err++;
  end

  typedef struct {
    logic        do_load;
    logic [11:0] w1;
    logic        load2;
    logic [11:0] w2;
    logic [11:0] mosi_w;
    int          nbits;
    logic [11:0] exp_miso;
    int          exp_under;
    int          exp_err;
    int          exp_valid;
    logic [11:0] exp_rx;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [11:0] w);
    bus.tx_data = w;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  // Master side: mosi out on rise, miso sampled at fall. load_at>=0 pulses tx_load at that setup cycle.
  task automatic spi_frame(input logic [11:0] mw, input int nbits, input int gap,
                           input int load_at, input logic [11:0] lw,
                           output logic [11:0] sw, output logic extra_nz);
    sw = '0;
    extra_nz = 1'b0;
    bus.cs = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == load_at) load_word(lw);
      else @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      bus.sclk = 1'b1;
      bus.mosi = (i < 12) ? mw[11-i] : 1'b1;
      repeat (5) @(negedge clk);
      if (i < 12) sw[11-i] = bus.miso;
      else if (bus.miso) extra_nz = 1'b1;
      bus.sclk = 1'b0;
      repeat (5) @(negedge clk);
    end
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  logic [11:0] sw, sw2, mask, w, mw, exp_miso;
  logic        nz, mdl_full;
  logic [11:0] mdl_hold, mdl_rx;
  int          b_v, b_u, b_e, nb, nloads;

  initial begin
    tbl[0] = '{1'b1, 12'h3F1, 1'b0, 12'h000, 12'hA5C, 12, 12'h3F1, 0, 0, 1, 12'hA5C};
    tbl[1] = '{1'b0, 12'h000, 1'b0, 12'h000, 12'h001, 12, 12'h000, 1, 0, 1, 12'h001};
    tbl[2] = '{1'b0, 12'h000, 1'b0, 12'h000, 12'hFFF,  5, 12'h000, 1, 1, 0, 12'h001};
    tbl[3] = '{1'b0, 12'h000, 1'b0, 12'h000, 12'h7E7, 12, 12'h000, 1, 0, 1, 12'h7E7};
    tbl[4] = '{1'b1, 12'hAAA, 1'b1, 12'h555, 12'h0F0, 12, 12'hAAA, 0, 0, 1, 12'h0F0};
    tbl[5] = '{1'b0, 12'h000, 1'b0, 12'h000, 12'h800, 14, 12'h000, 1, 0, 1, 12'h800};

    rst = 1'b1;
    bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    bus.tx_load = 1'b0; bus.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_miso", bus.miso, 0);
    chk("reset_tx_ready", bus.tx_ready, 1);
    chk("reset_rx_data", bus.rx_data, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_pulses", {bus.rx_valid, bus.tx_underrun, bus.frame_err}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      b_v = n_valid; b_u = n_under; b_e = n_err;
      if (tbl[r].do_load) load_word(tbl[r].w1);
      if (tbl[r].load2)   load_word(tbl[r].w2);
      spi_frame(tbl[r].mosi_w, tbl[r].nbits, 8, -1, 12'h000, sw, nz);
      mask = (tbl[r].nbits >= 12) ? 12'hFFF : (12'hFFF << (12 - tbl[r].nbits));
      chk($sformatf("tbl%0d_miso", r), sw & mask, tbl[r].exp_miso & mask);
      chk($sformatf("tbl%0d_underrun", r), n_under - b_u, tbl[r].exp_under);
      chk($sformatf("tbl%0d_frame_err", r), n_err - b_e, tbl[r].exp_err);
      chk($sformatf("tbl%0d_rx_valid", r), n_valid - b_v, tbl[r].exp_valid);
      chk($sformatf("tbl%0d_rx_data", r), bus.rx_data, tbl[r].exp_rx);
      chk($sformatf("tbl%0d_busy", r), bus.busy, 0);
      chk($sformatf("tbl%0d_tx_ready", r), bus.tx_ready, 1);
      chk($sformatf("tbl%0d_extra_miso", r), nz, 0);
    end

    // Back-to-back frames, second word reloaded while the first frame runs.
    b_v = n_valid; b_u = n_under;
    load_word(12'h123);
    spi_frame(12'h6D2, 12, 1, 4, 12'h456, sw, nz);
    spi_frame(12'h39B, 12, 8, -1, 12'h000, sw2, nz);
    chk("b2b_first_word", sw, 12'h123);
    chk("b2b_second_word", sw2, 12'h456);
    chk("b2b_rx_valid", n_valid - b_v, 2);
    chk("b2b_underrun", n_under - b_u, 0);
    chk("b2b_rx_data", bus.rx_data, 12'h39B);

    // tx_load in the frame-start cycle: zeros now, word kept for the next frame.
    b_u = n_under;
    spi_frame(12'h111, 12, 8, 2, 12'h9C3, sw, nz);
    chk("startload_miso", sw, 0);
    chk("startload_underrun", n_under - b_u, 1);
    chk("startload_tx_ready", bus.tx_ready, 0);
    spi_frame(12'h222, 12, 8, -1, 12'h000, sw, nz);
    chk("startload_next_word", sw, 12'h9C3);
    chk("startload_next_underrun", n_under - b_u, 1);

    // Reset after 6 bits aborts silently and empties the holding reg.
    load_word(12'h5A5);
    b_v = n_valid; b_e = n_err;
    spi_frame(12'hC3C, 6, 0, -1, 12'h000, sw, nz);
    chk("midframe_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_miso", bus.miso, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_tx_ready", bus.tx_ready, 1);
    chk("rst_mid_rx_data", bus.rx_data, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mid_no_pulses", (n_valid - b_v) + (n_err - b_e), 0);
    load_word(12'h1B7);
    spi_frame(12'h2C8, 12, 8, -1, 12'h000, sw, nz);
    chk("rst_next_word", sw, 12'h1B7);
    chk("rst_next_rx", bus.rx_data, 12'h2C8);

    // Random frames against a word-level model of holding reg and receive word.
    mdl_full = 1'b0; mdl_hold = '0; mdl_rx = 12'h2C8;
    for (int it = 0; it < 40; it++) begin
      nloads = $urandom_range(0, 2);
      for (int l = 0; l < nloads; l++) begin
        w = 12'($urandom);
        chk("rnd_tx_ready", bus.tx_ready, !mdl_full);
        if (!mdl_full) begin
          mdl_full = 1'b1;
          mdl_hold = w;
        end
        load_word(w);
      end
      case ($urandom_range(0, 9))
        7:       nb = $urandom_range(2, 11);
        8, 9:    nb = $urandom_range(13, 14);
        default: nb = 12;
      endcase
      mw = 12'($urandom);
      exp_miso = mdl_full ? mdl_hold : 12'h000;
      b_v = n_valid; b_u = n_under; b_e = n_err;
      spi_frame(mw, nb, 8, -1, 12'h000, sw, nz);
      chk("rnd_underrun", n_under - b_u, mdl_full ? 0 : 1);
      mdl_full = 1'b0;
      mask = (nb >= 12) ? 12'hFFF : (12'hFFF << (12 - nb));
      chk("rnd_miso", sw & mask, exp_miso & mask);
      chk("rnd_extra_miso", nz, 0);
      if (nb >= 12) mdl_rx = mw;
      chk("rnd_rx_valid", n_valid - b_v, (nb >= 12) ? 1 : 0);
      chk("rnd_frame_err", n_err - b_e, (nb >= 12) ? 0 : 1);
      chk("rnd_rx_data", bus.rx_data, mdl_rx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
